// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_REQ    = 3'd1,
        FS_WAIT   = 3'd2,
        FS_HOLD   = 3'd3,
        FS_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch, or jump (jump wins).
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [WORD_W-1:0] instr_pc,
    input  logic [WORD_W-1:0] instr,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] p4;
    logic [WORD_W-1:0] br_off;
    logic              unused_opcode;

    assign p4            = instr_pc + PC_STEP;
    assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    // Select the successor address; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = p4;
        if (jump) begin
            next_pc = {p4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = p4 + br_off;
        end else begin
            next_pc = p4;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Stall-tolerant single-outstanding fetch sequencer for the MIPS core.
// Optional FETCH_PERF_EN adds fetch_count and stall_cycles counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              halt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_cycles
`endif
);

    fetch_state_e      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] next_pc;

    next_pc_calc u_next_pc (
        .instr_pc (instr_pc),
        .instr    (instr),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    // Fetch FSM with registered handshake and hold-register outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FS_IDLE;
            pc          <= RESET_ADDR;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_ADDR;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
        end else begin
            case (state)
                FS_IDLE: begin
                    state     <= FS_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FS_REQ: begin
                    // rvalid in the grant cycle belongs to no request of ours.
                    if (imem_gnt) begin
                        state    <= FS_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        state       <= FS_HOLD;
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    // branch/zero/jump/halt are only looked at under accept.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        if (halt) begin
                            state <= FS_HALTED;
                        end else begin
                            state     <= FS_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                        end
                    end
                end
                FS_HALTED: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= FS_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Accepted-instruction and memory-stall counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (state == FS_HOLD && instr_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end else begin
                fetch_count <= fetch_count;
            end
            if (state == FS_REQ || state == FS_WAIT) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl (main instance plus a wrap-around instance).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        halt = 1'b0;

    logic        req2;
    logic [31:0] addr2;
    logic        gnt2 = 1'b0;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic        ready2 = 1'b0;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_cycles, fc2, sc2;
`endif

    int vecs = 0;
    int fails = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] pc_q[$];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .branch(branch), .zero(zero),
        .jump(jump), .halt(halt)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
    );

    fetch_ctrl #(.RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr(instr2), .instr_pc(ipc2),
        .instr_ready(ready2), .branch(1'b0), .zero(1'b0),
        .jump(1'b0), .halt(1'b0)
`ifdef FETCH_PERF_EN
        , .fetch_count(fc2), .stall_cycles(sc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_or_bad(inout logic [31:0] q[$]);
        if (q.size() == 0) return 32'hBAAD_F00D;
        return q.pop_front();
    endfunction

    // One complete fetch with programmable gnt/rvalid/ready delays.
    task automatic do_fetch(input logic [31:0] rdata, input int gdly, input int rdly,
                            input int ydly, input logic br, input logic z,
                            input logic j, input logic h, input logic [31:0] nxt,
                            input logic perf_chk);
        logic [31:0] ea, ei, ep;
        int n;
`ifdef FETCH_PERF_EN
        logic [31:0] sc0, fc0;
`endif
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        ea = pop_or_bad(addr_q);
        chk("fetch_addr", imem_addr, ea);
`ifdef FETCH_PERF_EN
        sc0 = stall_cycles;
        fc0 = fetch_count;
`endif
        repeat (gdly) begin
            @(negedge clk);
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, ea);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("req_drop", {31'd0, imem_req}, 32'd0);
        repeat (rdly) begin
            @(negedge clk);
            chk("no_dup_req", {31'd0, imem_req}, 32'd0);
            chk("wait_invalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = rdata;
        instr_q.push_back(rdata);
        pc_q.push_back(ea);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        ei = pop_or_bad(instr_q);
        ep = pop_or_bad(pc_q);
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, ei);
        chk("instr_pc", instr_pc, ep);
`ifdef FETCH_PERF_EN
        if (perf_chk) chk("stall_cycles", stall_cycles - sc0, 32'(gdly + rdly + 2));
`endif
        repeat (ydly) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, ei);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        branch = br;
        zero   = z;
        jump   = j;
        halt   = h;
        @(negedge clk);
        instr_ready = 1'b0;
        branch = 1'bx;
        zero   = 1'bx;
        jump   = 1'bx;
        halt   = 1'bx;
        chk("accept_clear", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count - fc0, 32'd1);
`endif
        if (!h) addr_q.push_back(nxt);
    endtask

    initial begin
        int n;
        // Reset held three cycles; outputs stay at reset values throughout.
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
        end
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("idle_noreq", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        addr_q.push_back(32'h0);

        // Sequential, branches, jump priority, then a stalled fetch.
        do_fetch(32'h1111_1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b1);
        do_fetch(32'h2222_2222, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1);
        do_fetch(32'h0000_1000, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_400C, 1'b1);
        do_fetch(32'h0000_FF98, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3E70, 1'b1);
        do_fetch(32'h0008_0000, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0020_0000, 1'b1);
        do_fetch(32'h3333_3333, 3, 2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0020_0004, 1'b1);

        // Fresh reset: untaken branch goes sequential.
        @(negedge clk);
        reset = 1'b1;
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        addr_q.push_back(32'h0);
        do_fetch(32'h4444_4444, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b1);
        do_fetch(32'h5555_5555, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1);
        do_fetch(32'h0000_1000, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1);

        // Reset during WAIT, then a stale rvalid in IDLE and REQ.
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_addr", imem_addr, pop_or_bad(addr_q));
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("stale_idle", {31'd0, instr_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("stale_req_state", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b0;
        addr_q.push_back(32'h0);

        // Halt on accept: no further requests.
        do_fetch(32'h6666_6666, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("halted_noreq", {31'd0, imem_req}, 32'd0);
            chk("halted_invalid", {31'd0, instr_valid}, 32'd0);
        end

        // Wrap-around instance: RESET_ADDR FFFF_FFFC then 0.
        chk("wrap_req", {31'd0, req2}, 32'd1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1;
        @(negedge clk);
        gnt2 = 1'b0;
        rvalid2 = 1'b1;
        rdata2  = 32'h0000_1234;
        @(negedge clk);
        rvalid2 = 1'b0;
        chk("wrap_valid", {31'd0, valid2}, 32'd1);
        chk("wrap_ipc", ipc2, 32'hFFFF_FFFC);
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        chk("wrap_req2", {31'd0, req2}, 32'd1);
        chk("wrap_addr1", addr2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
